// File: rtl/regfile_defs.sv
// rtl/regfile_defs.sv - shared register-file constants and decode encodings
//
// Purpose: default geometry for the 2-read/1-write register file and the operand
//          select encoding decode uses when steering register-file outputs.
// Ports:   none (package).

package regfile_defs;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   // Operand source chosen by decode for each ALU input.
   typedef enum logic [1:0] {
      OPSEL_REG  = 2'd0,
      OPSEL_IMM  = 2'd1,
      OPSEL_PC   = 2'd2,
      OPSEL_ZERO = 2'd3
   } opsel_e;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port of the register file
//
// Purpose: resolves one read per cycle (zero-entry, clear, bypass, array) and
//          holds the last result while the port is disabled.
// Ports:   clock, reset          - clock, async active-high reset
//          clr                   - synchronous clear of the whole file
//          re, a                 - read enable and address
//          mem_data, mem_valid   - array contents/valid flag at address a
//          wr_en, wa, wd         - write actually committing this cycle
//          rd, rd_valid          - registered read result

module regfile_read_port #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              re,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd,
   output logic              rd_valid
);

   logic [DATA_W-1:0] rd_q, rd_d;
   logic              rd_valid_q, rd_valid_d;

   always_comb begin
      rd_d       = rd_q;
      rd_valid_d = rd_valid_q;
      if (re) begin
         // Hardwired zero entry wins even over clr.
         if ((ZERO_REG != 0) && (a == '0)) begin
            rd_d       = '0;
            rd_valid_d = 1'b1;
         end else if (clr) begin
            rd_d       = '0;
            rd_valid_d = 1'b0;
         end else if ((BYPASS != 0) && wr_en && (wa == a)) begin
            // wr_en already excludes dropped writes and clr.
            rd_d       = wd;
            rd_valid_d = 1'b1;
         end else begin
            rd_d       = mem_data;
            rd_valid_d = mem_valid;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd       = rd_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - parametrised register file, one write and two read ports
//
// Purpose: storage array with per-entry valid flags, synchronous clear-all and
//          two independent registered read ports (optional bypass, optional
//          hardwired-zero entry 0).
// Ports:   clock, reset              - clock, async active-high reset
//          clr                       - clear all entries and valid flags
//          we, wa, wd                - write port
//          re1, a1 / rd1, rd1_valid  - read port 1
//          re2, a2 / rd2, rd2_valid  - read port 2

module regfile_2r1w
   import regfile_defs::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              re1,
   input  logic [ADDR_W-1:0] a1,
   output logic [DATA_W-1:0] rd1,
   output logic              rd1_valid,
   input  logic              re2,
   input  logic [ADDR_W-1:0] a2,
   output logic [DATA_W-1:0] rd2,
   output logic              rd2_valid
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic              wr_en;

   // Writes to the hardwired-zero entry are dropped; clr drops any write.
   assign wr_en = we && !clr && !((ZERO_REG != 0) && (wa == '0));

   always_comb begin
      mem_d   = mem_q;
      valid_d = valid_q;
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
         valid_d = '0;
      end else if (wr_en) begin
         mem_d[wa]   = wd;
         valid_d[wa] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         mem_q   <= mem_d;
         valid_q <= valid_d;
      end
   end

   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_port1 (
      .clock     (clock),
      .reset     (reset),
      .clr       (clr),
      .re        (re1),
      .a         (a1),
      .mem_data  (mem_q[a1]),
      .mem_valid (valid_q[a1]),
      .wr_en     (wr_en),
      .wa        (wa),
      .wd        (wd),
      .rd        (rd1),
      .rd_valid  (rd1_valid)
   );

   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_port2 (
      .clock     (clock),
      .reset     (reset),
      .clr       (clr),
      .re        (re2),
      .a         (a2),
      .mem_data  (mem_q[a2]),
      .mem_valid (valid_q[a2]),
      .wr_en     (wr_en),
      .wa        (wa),
      .wd        (wd),
      .rd        (rd2),
      .rd_valid  (rd2_valid)
   );

endmodule
